// File: rtl/echo_indication_deserializer.sv
// Deserialises a 32-bit header+payload stream into a 96-bit heard message; one cycle from last payload word to enq__ENA.
// A held message deasserts in__RDY until enq__RDY takes it; unknown or malformed messages are skipped and counted.
module echo_indication_deserializer #(
    parameter int METHOD_HEARD = 0,
    parameter int TAG_HEARD    = 1,
    parameter int HEARD_LEN    = 2,
    parameter int DROP_WIDTH   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in__ENA,
    input  logic [31:0]           in_data,
    output logic                  in__RDY,
    output logic                  enq__ENA,
    output logic [95:0]           enq_v,
    input  logic                  enq__RDY,
    output logic [DROP_WIDTH-1:0] drop_count
);

    typedef struct packed {
        logic [15:0] meth_id;
        logic [15:0] len;
    } hdr_t;

    typedef struct packed {
        logic [31:0] v;
        logic [31:0] meth;
        logic [31:0] tag;
    } msg_t;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DISCARD,
        HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     remaining, remaining_nxt;
    logic            word_idx, word_idx_nxt;
    logic [31:0]     meth_r, meth_nxt;
    logic [31:0]     v_r, v_nxt;
    logic            drop_inc;
    hdr_t            hdr;
    msg_t            msg;

    assign hdr = hdr_t'(in_data);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            remaining  <= '0;
            word_idx   <= 1'b0;
            meth_r     <= '0;
            v_r        <= '0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            word_idx  <= word_idx_nxt;
            meth_r    <= meth_nxt;
            v_r       <= v_nxt;
            // Saturate rather than wrap so a flood of bad traffic stays visible.
            if (drop_inc && (drop_count != {DROP_WIDTH{1'b1}}))
                drop_count <= drop_count + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        word_idx_nxt  = word_idx;
        meth_nxt      = meth_r;
        v_nxt         = v_r;
        drop_inc      = 1'b0;
        case (state)
            IDLE: begin
                if (in__ENA) begin
                    if ((hdr.meth_id == 16'(METHOD_HEARD)) && (hdr.len == 16'(HEARD_LEN))) begin
                        state_nxt    = PAYLOAD;
                        word_idx_nxt = 1'b0;
                    end else begin
                        drop_inc = 1'b1;
                        if (hdr.len != 16'd0) begin
                            state_nxt     = DISCARD;
                            remaining_nxt = hdr.len;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (in__ENA) begin
                    if (!word_idx) begin
                        meth_nxt     = in_data;
                        word_idx_nxt = 1'b1;
                    end else begin
                        v_nxt     = in_data;
                        state_nxt = HOLD;
                    end
                end
            end
            DISCARD: begin
                if (in__ENA) begin
                    remaining_nxt = remaining - 16'd1;
                    if (remaining == 16'd1)
                        state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (enq__RDY)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready depends on state only, so no combinational path from enq__RDY.
    assign in__RDY  = (state != HOLD);
    assign enq__ENA = (state == HOLD);

    always_comb begin
        msg.v    = v_r;
        msg.meth = meth_r;
        msg.tag  = 32'(TAG_HEARD);
        enq_v    = enq__ENA ? 96'(msg) : 96'd0;
    end

endmodule

// File: tb/tb_echo_indication_deserializer.sv
module tb_echo_indication_deserializer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in__ENA = 1'b0;
    logic [31:0] in_data = '0;
    logic        enq__RDY = 1'b1;
    logic        in__RDY, enq__ENA;
    logic [95:0] enq_v;
    logic [15:0] drop_count;
    logic        in_rdy2, enq_ena2;
    logic [95:0] enq_v2;
    logic [1:0]  drop_count2;

    int errors = 0;
    int checks = 0;
    int drops  = 0;
    bit rdy_rand = 1'b0;
    logic [95:0] exp_q[$];

    always #5 CLK = ~CLK;

    echo_indication_deserializer dut (
        .CLK(CLK), .RST(RST), .in__ENA(in__ENA), .in_data(in_data), .in__RDY(in__RDY),
        .enq__ENA(enq__ENA), .enq_v(enq_v), .enq__RDY(enq__RDY), .drop_count(drop_count)
    );

    echo_indication_deserializer #(.DROP_WIDTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .in__ENA(in__ENA), .in_data(in_data), .in__RDY(in_rdy2),
        .enq__ENA(enq_ena2), .enq_v(enq_v2), .enq__RDY(enq__RDY), .drop_count(drop_count2)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard monitor: every presented message must match the queue head.
    always @(negedge CLK) begin
        if (!RST && enq__ENA) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_msg", enq_v, 96'd0);
                if (enq_v == 96'd0) fail_now("unexpected_msg_zero");
            end else begin
                chk("msg", enq_v, exp_q[0]);
                chk("msg_w2", enq_v2, exp_q[0]);
                chk("ena_w2", 96'(enq_ena2), 96'd1);
                chk("in_rdy_hold", 96'({in__RDY, in_rdy2}), 96'd0);
                if (enq__RDY) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (rdy_rand) enq__RDY = 1'($urandom_range(0, 1));
    end

    task automatic send_word(input logic [31:0] w, input int gap);
        int n = 0;
        while (!in__RDY && n < 200) begin
            @(posedge CLK); #1; n++;
        end
        if (!in__RDY) fail_now("in_rdy_wait");
        in__ENA = 1'b1;
        in_data = w;
        @(posedge CLK); #1;
        in__ENA = 1'b0;
        in_data = $urandom;
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    // Reference model: heard iff method 0 and length 2; anything else counts one drop.
    task automatic send_msg(input logic [31:0] hdr, input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] p2, input logic [31:0] p3, input int gap);
        logic [31:0] p[4];
        int len;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        len = int'(hdr[15:0]);
        if (hdr[31:16] == 16'd0 && len == 2) exp_q.push_back({p1, p0, 32'd1});
        else drops++;
        send_word(hdr, gap);
        for (int i = 0; i < len; i++) send_word(p[i], (i == len - 1) ? 0 : gap);
    endtask

    task automatic chk_drops(input string name);
        chk({name, "_cnt"}, 96'(drop_count), 96'((drops > 65535) ? 65535 : drops));
        chk({name, "_cnt2"}, 96'(drop_count2), 96'((drops > 3) ? 3 : drops));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge CLK); #1; n++; end
        if (exp_q.size() != 0) begin
            fail_now("drain");
            exp_q.delete();
        end
        repeat (2) begin @(posedge CLK); #1; end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in__ENA = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        drops = 0;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hdr;
        repeat (2) @(posedge CLK);
        #1;
        do_reset();
        chk("rst_in_rdy", 96'(in__RDY), 96'd1);
        chk("rst_enq_ena", 96'(enq__ENA), 96'd0);
        chk("rst_enq_v", enq_v, 96'd0);
        chk_drops("rst");

        // Basic message and one-cycle latency.
        enq__RDY = 1'b1;
        send_msg(32'h0000_0002, 32'h0000_0007, 32'h1234_5678, 0, 0, 0);
        chk("lat_ena", 96'(enq__ENA), 96'd1);
        chk("lat_v", enq_v, 96'h12345678_00000007_00000001);
        @(posedge CLK); #1;
        chk("after_ena", 96'(enq__ENA), 96'd0);
        chk("after_rdy", 96'(in__RDY), 96'd1);
        drain();

        // Backpressure hold.
        enq__RDY = 1'b0;
        send_msg(32'h0000_0002, 32'h0000_0007, 32'h1234_5678, 0, 0, 0);
        repeat (5) begin
            chk("bp_ena", 96'(enq__ENA), 96'd1);
            chk("bp_rdy", 96'(in__RDY), 96'd0);
            @(posedge CLK); #1;
        end
        enq__RDY = 1'b1;
        @(posedge CLK); #1;
        chk("bp_release", 96'(enq__ENA), 96'd0);
        drain();

        // Discarded messages, zero-length header, then a good one.
        do_reset();
        send_msg(32'h0005_0003, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 0, 0);
        chk_drops("disc");
        send_msg(32'h0000_0003, 32'h1, 32'h2, 32'h3, 0, 0);
        chk_drops("wrong_len");
        send_msg(32'h0009_0000, 0, 0, 0, 0, 0);
        chk_drops("zero_len");
        send_msg(32'h0000_0002, 32'hCAFE_F00D, 32'h0BAD_BEEF, 0, 0, 0);
        drain();

        // Reset mid-message loses it without counting.
        send_word(32'h0000_0002, 0);
        send_word(32'h0000_0055, 0);
        do_reset();
        chk_drops("mid_rst");
        send_msg(32'h0000_0002, 32'h0000_000A, 32'h0000_000B, 0, 0, 0);
        drain();
        chk_drops("mid_rst_after");

        // Gapped input gives identical message.
        send_msg(32'h0000_0002, 32'h0000_0007, 32'h1234_5678, 0, 0, 1);
        drain();

        // Saturation of the narrow counter.
        repeat (5) send_msg(32'h0003_0000, 0, 0, 0, 0, 0);
        chk_drops("sat");

        // Randomised traffic with random downstream backpressure.
        rdy_rand = 1'b1;
        for (int m = 0; m < 60; m++) begin
            int kind = $urandom_range(0, 3);
            case (kind)
                0, 1: hdr = 32'h0000_0002;
                2:    hdr = {16'h0000, 16'($urandom_range(0, 4))};
                default: hdr = {16'($urandom_range(1, 65535)), 16'($urandom_range(0, 4))};
            endcase
            send_msg(hdr, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 2));
            if (m % 10 == 9) chk_drops("rand");
        end
        rdy_rand = 1'b0;
        enq__RDY = 1'b1;
        drain();
        chk_drops("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
